// File: rtl/dport_bridge_if.sv
// dport_bridge_if: data-port request/response bundle shared by the cpu, tcm and ext sides of dport_bridge
interface dport_bridge_if;
  logic [31:0] addr;
  logic [31:0] data_wr;
  logic        rd;
  logic [3:0]  wr;
  logic        cacheable;
  logic        invalidate;
  logic        writeback;
  logic        flush;
  logic [10:0] req_tag;
  logic        accept;
  logic        ack;
  logic        error;
  logic [31:0] data_rd;
  logic [10:0] resp_tag;
  modport master (
    output addr, data_wr, rd, wr, cacheable, invalidate, writeback, flush, req_tag,
    input  accept, ack, error, data_rd, resp_tag
  );
  modport slave (
    input  addr, data_wr, rd, wr, cacheable, invalidate, writeback, flush, req_tag,
    output accept, ack, error, data_rd, resp_tag
  );
endinterface

// File: rtl/dport_bridge.sv
// dport_bridge: routes cpu data requests to tcm or ext by address and returns responses in issue order.
// Optional DPORT_TIMEOUT_EN: an ext request unacked for TIMEOUT_CYCLES completes with an error response.
module dport_bridge #(
  parameter logic [31:0] TCM_BASE       = 32'h80000000,
  parameter logic [31:0] TCM_MASK       = 32'hFFFE0000,
  parameter int          OUTST_DEPTH    = 4,
  parameter int          TIMEOUT_CYCLES = 1024
) (
  input  logic           clk,
  input  logic           rst_n,
  dport_bridge_if.slave  cpu,
  dport_bridge_if.master tcm,
  dport_bridge_if.master ext
);
  localparam int PW = $clog2(OUTST_DEPTH);
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic          fifo_ext [OUTST_DEPTH];
  logic          last_ext, maint, req, sel_ext, stall, to_tcm, to_ext, issue;
  logic          nonempty, head_ext, tcm_hit, ext_hit, timeout, pop;
  logic [10:0]   head_tag;
  assign maint    = cpu.flush | cpu.invalidate | cpu.writeback;
  assign req      = cpu.rd | (|cpu.wr) | maint;
  assign sel_ext  = !maint && ((cpu.addr & TCM_MASK) != TCM_BASE);
  assign nonempty = count != '0;
  // a port switch waits for every outstanding response so ordering needs only one port per drain
  assign stall    = (count == (PW+1)'(OUTST_DEPTH)) || (nonempty && (sel_ext != last_ext));
  assign to_tcm   = !stall && !sel_ext;
  assign to_ext   = !stall && sel_ext;
  assign issue    = req && !stall && (sel_ext ? ext.accept : tcm.accept);
  assign cpu.accept = issue;
  assign tcm.addr       = cpu.addr;
  assign tcm.data_wr    = cpu.data_wr;
  assign tcm.req_tag    = cpu.req_tag;
  assign tcm.cacheable  = cpu.cacheable;
  assign tcm.rd         = to_tcm & cpu.rd;
  assign tcm.wr         = to_tcm ? cpu.wr : 4'h0;
  assign tcm.flush      = to_tcm & cpu.flush;
  assign tcm.invalidate = to_tcm & cpu.invalidate;
  assign tcm.writeback  = to_tcm & cpu.writeback;
  assign ext.addr       = cpu.addr;
  assign ext.data_wr    = cpu.data_wr;
  assign ext.req_tag    = cpu.req_tag;
  assign ext.cacheable  = cpu.cacheable;
  assign ext.rd         = to_ext & cpu.rd;
  assign ext.wr         = to_ext ? cpu.wr : 4'h0;
  assign ext.flush      = to_ext & cpu.flush;
  assign ext.invalidate = to_ext & cpu.invalidate;
  assign ext.writeback  = to_ext & cpu.writeback;
  assign head_ext = fifo_ext[rd_ptr];
  assign tcm_hit  = nonempty && !head_ext && tcm.ack;
  assign ext_hit  = nonempty && head_ext && ext.ack;
  assign pop      = tcm_hit | ext_hit | timeout;
  assign cpu.ack      = pop;
  assign cpu.error    = tcm_hit ? tcm.error : ext_hit ? ext.error : timeout;
  assign cpu.data_rd  = tcm_hit ? tcm.data_rd : ext_hit ? ext.data_rd : 32'h0;
  assign cpu.resp_tag = tcm_hit ? tcm.resp_tag : ext_hit ? ext.resp_tag : timeout ? head_tag : 11'h0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      last_ext <= 1'b0;
    end else begin
      if (issue) begin
        wr_ptr   <= wr_ptr + 1'b1;
        last_ext <= sel_ext;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{PW{1'b0}}, issue} - {{PW{1'b0}}, pop};
    end
  end
  always_ff @(posedge clk) begin
    if (issue) fifo_ext[wr_ptr] <= sel_ext;
  end
`ifdef DPORT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt;
  logic [10:0]   fifo_tag [OUTST_DEPTH];
  assign timeout  = nonempty && head_ext && !ext.ack && (tcnt == TW'(TIMEOUT_CYCLES));
  assign head_tag = fifo_tag[rd_ptr];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tcnt <= '0;
    else tcnt <= (nonempty && head_ext && !ext.ack && !timeout) ? tcnt + 1'b1 : '0;
  end
  always_ff @(posedge clk) begin
    if (issue) fifo_tag[wr_ptr] <= cpu.req_tag;
  end
`else
  assign timeout  = 1'b0;
  assign head_tag = 11'h0;
`endif
  // acks with no matching outstanding entry are discarded; flag them in simulation
  always_ff @(posedge clk) begin
    if (rst_n) assert (!(tcm.ack && !tcm_hit) && !(ext.ack && !ext_hit))
      else $warning("dport_bridge: ack dropped, no matching outstanding request");
  end
endmodule
